// File: rtl/if_pkg.sv
// Shared IF-stage definitions: run-control state encoding and PC defaults.
package if_pkg;

  localparam int unsigned SIZE_ADDR_PC = 32;
  localparam int unsigned PC_STEP      = 4;

  // Encoding is visible on o_state, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: branch target over jump target over sequential PC + step.
module pc_next_mux
  import if_pkg::*;
#(
  parameter int unsigned W    = SIZE_ADDR_PC,
  parameter int unsigned Step = PC_STEP
) (
  input  logic [W-1:0] i_pc,
  input  logic         i_jump,
  input  logic [W-1:0] i_jump_addr,
  input  logic         i_branch,
  input  logic [W-1:0] i_branch_addr,
  output logic [W-1:0] o_next_pc
);

  localparam logic [W-1:0] StepVec = W'(Step);

  logic [W-1:0] seq_pc;

  // Sequential address wraps modulo 2^W.
  always_comb begin
    seq_pc = i_pc + StepVec;
    if (i_branch) begin
      o_next_pc = i_branch_addr;
    end else if (i_jump) begin
      o_next_pc = i_jump_addr;
    end else begin
      o_next_pc = seq_pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage run control and next-PC generation.
// Optional executed-cycle counter enabled by defining PCSEQ_CYCLE_CNT_EN;
// without it o_cycle_cnt is tied to zero and no counter is built.
module pc_sequencer
  import if_pkg::*;
#(
  parameter int unsigned SIZE_ADDR_PC = if_pkg::SIZE_ADDR_PC,
  parameter int unsigned PC_STEP      = if_pkg::PC_STEP,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_run_cont,
  input  logic                    i_run_step,
  input  logic [SIZE_ADDR_PC-1:0] i_pc,
  input  logic                    i_stall,
  input  logic                    i_jump,
  input  logic [SIZE_ADDR_PC-1:0] i_jump_addr,
  input  logic                    i_branch,
  input  logic [SIZE_ADDR_PC-1:0] i_branch_addr,
  input  logic                    i_halt_fetched,
  output logic [SIZE_ADDR_PC-1:0] o_next_pc,
  output logic                    o_pc_enable,
  output logic                    o_flush_ifid,
  output logic [1:0]              o_state,
  output logic                    o_halted,
  output logic [CNT_W-1:0]        o_cycle_cnt
);

  state_e state_q, state_d;
  logic   halted_q;
  logic   active;
  logic   halt_now;

  pc_next_mux #(
    .W    (SIZE_ADDR_PC),
    .Step (PC_STEP)
  ) u_pc_next_mux (
    .i_pc          (i_pc),
    .i_jump        (i_jump),
    .i_jump_addr   (i_jump_addr),
    .i_branch      (i_branch),
    .i_branch_addr (i_branch_addr),
    .o_next_pc     (o_next_pc)
  );

  // Enable/flush decode; a HALT only takes effect when no redirect squashes it.
  always_comb begin
    active       = (state_q == ST_RUN) || (state_q == ST_STEP);
    halt_now     = active & i_halt_fetched & ~i_branch & ~i_jump;
    o_pc_enable  = active & (~i_stall | i_branch) & ~halt_now;
    o_flush_ifid = active & (i_branch | (i_jump & ~i_stall));
  end

  // Next-state: run pulses only honoured in IDLE, continuous run wins over step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_run_cont) begin
          state_d = ST_RUN;
        end else if (i_run_step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_now) state_d = ST_HALT;
      end
      ST_STEP: begin
        if (halt_now) begin
          state_d = ST_HALT;
        end else if (o_pc_enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Run-control state and registered halted flag.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign o_state  = state_q;
  assign o_halted = halted_q;

`ifdef PCSEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count edges spent in RUN/STEP, saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (active && (cnt_q != '1)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cycle_cnt = cnt_q;
`else
  assign o_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, corner sequences and
// randomized traffic against a rule-level reference model.
module tb_pc_sequencer;

`ifdef PCSEQ_CYCLE_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;
  localparam longint CntMax = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_cont, run_step, stall, jump, branch, halt_f;
  logic [31:0] pc, jump_addr, branch_addr;
  logic [31:0] next_pc;
  logic        pc_en, flush, halted;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int     m_state;
  longint m_cnt;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_run_cont     (run_cont),
    .i_run_step     (run_step),
    .i_pc           (pc),
    .i_stall        (stall),
    .i_jump         (jump),
    .i_jump_addr    (jump_addr),
    .i_branch       (branch),
    .i_branch_addr  (branch_addr),
    .i_halt_fetched (halt_f),
    .o_next_pc      (next_pc),
    .o_pc_enable    (pc_en),
    .o_flush_ifid   (flush),
    .o_state        (state),
    .o_halted       (halted),
    .o_cycle_cnt    (cycle_cnt)
  );

  typedef struct {
    logic        rc, rs;
    logic [31:0] pc;
    logic        st, jp;
    logic [31:0] ja;
    logic        br;
    logic [31:0] ba;
    logic        hf;
    logic [1:0]  e_state;
    logic        e_en, e_fl;
    logic [31:0] e_next;
  } vec_t;

  function automatic vec_t mk(input logic rc, input logic rs, input logic [31:0] p,
                              input logic st, input logic jp, input logic [31:0] ja,
                              input logic br, input logic [31:0] ba, input logic hf,
                              input logic [1:0] es, input logic ee, input logic ef,
                              input logic [31:0] en);
    vec_t v;
    v.rc = rc; v.rs = rs; v.pc = p; v.st = st; v.jp = jp; v.ja = ja;
    v.br = br; v.ba = ba; v.hf = hf; v.e_state = es; v.e_en = ee; v.e_fl = ef;
    v.e_next = en;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    run_cont = 1'b0; run_step = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0;
    halt_f = 1'b0; pc = 32'h0; jump_addr = 32'h0; branch_addr = 32'h0;
  endtask

  task automatic apply(input vec_t v);
    run_cont = v.rc; run_step = v.rs; pc = v.pc; stall = v.st; jump = v.jp;
    jump_addr = v.ja; branch = v.br; branch_addr = v.ba; halt_f = v.hf;
  endtask

  // Called at posedge+1: assert reset mid-cycle, check async effect, release after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    m_state = M_IDLE;
    m_cnt = 0;
    #1;
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_en", 64'(pc_en), 64'(0));
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    chk("rst_cnt", 64'(cycle_cnt), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock with the current inputs, checked against the model. Entry/exit at posedge+1.
  task automatic tick();
    bit          active, halt_req, e_en, e_fl;
    logic [31:0] e_next;
    #2;
    active   = (m_state == M_RUN) || (m_state == M_STEP);
    halt_req = active && halt_f && !branch && !jump;
    e_en     = active && (!stall || branch) && !halt_req;
    e_fl     = active && (branch || (jump && !stall));
    e_next   = branch ? branch_addr : jump ? jump_addr : pc + 32'd4;
    chk("next_pc", 64'(next_pc), 64'(e_next));
    chk("pc_enable", 64'(pc_en), 64'(e_en));
    chk("flush", 64'(flush), 64'(e_fl));
    chk("state", 64'(state), 64'(m_state));
    chk("halted", 64'(halted), 64'(m_state == M_HALT));
    chk("cycle_cnt", 64'(cycle_cnt), CntEn ? 64'(m_cnt) : 64'(0));
    @(posedge clk);
    if (active && m_cnt < CntMax) m_cnt++;
    case (m_state)
      M_IDLE: if (run_cont) m_state = M_RUN; else if (run_step) m_state = M_STEP;
      M_RUN:  if (halt_req) m_state = M_HALT;
      M_STEP: if (halt_req) m_state = M_HALT; else if (e_en) m_state = M_IDLE;
      default: ;
    endcase
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                  2'd0, 1'b0, 1'b0, 32'h14);
    vecs[1]  = mk(1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                  2'd2, 1'b1, 1'b0, 32'h14);
    vecs[2]  = mk(1'b0, 1'b0, 32'h14, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                  2'd0, 1'b0, 1'b0, 32'h18);
    vecs[3]  = mk(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                  2'd0, 1'b0, 1'b0, 32'h18);
    vecs[4]  = mk(1'b0, 1'b0, 32'h14, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0,
                  2'd1, 1'b1, 1'b1, 32'h40);
    vecs[5]  = mk(1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                  2'd1, 1'b0, 1'b0, 32'h44);
    vecs[6]  = mk(1'b0, 1'b0, 32'h44, 1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0,
                  2'd1, 1'b1, 1'b1, 32'h40);
    vecs[7]  = mk(1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                  2'd1, 1'b1, 1'b0, 32'h0);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0,
                  2'd1, 1'b0, 1'b0, 32'h80);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
                  2'd1, 1'b1, 1'b1, 32'h100);
    vecs[10] = mk(1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1,
                  2'd1, 1'b1, 1'b1, 32'h200);
    vecs[11] = mk(1'b0, 1'b0, 32'h200, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1,
                  2'd1, 1'b1, 1'b1, 32'h300);
    vecs[12] = mk(1'b0, 1'b0, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1,
                  2'd1, 1'b0, 1'b0, 32'h304);
    vecs[13] = mk(1'b1, 1'b0, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                  2'd3, 1'b0, 1'b0, 32'h304);
    vecs[14] = mk(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0,
                  2'd3, 1'b0, 1'b0, 32'h40);
    vecs[15] = mk(1'b0, 1'b0, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                  2'd3, 1'b0, 1'b0, 32'h304);

    clear_inputs();
    rst_n = 1'b0;
    m_state = M_IDLE;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table: step, run, stall/branch priority, wrap, halt and squash.
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      #2;
      chk($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].e_state));
      chk($sformatf("vec%0d_en", i), 64'(pc_en), 64'(vecs[i].e_en));
      chk($sformatf("vec%0d_flush", i), 64'(flush), 64'(vecs[i].e_fl));
      chk($sformatf("vec%0d_next", i), 64'(next_pc), 64'(vecs[i].e_next));
      chk($sformatf("vec%0d_halted", i), 64'(halted), 64'(vecs[i].e_state == 2'd3));
      @(posedge clk);
      #1;
    end

    // Step held by a stall, then completes and returns to IDLE.
    clear_inputs();
    do_reset();
    run_step = 1'b1; tick();
    run_step = 1'b0; stall = 1'b1; tick();
    chk("step_stalled_state", 64'(state), 64'(M_STEP));
    stall = 1'b0; tick();
    chk("step_done_state", 64'(state), 64'(M_IDLE));
    tick();

    // Reset asserted mid-run acts before the next edge.
    run_cont = 1'b1; tick();
    run_cont = 1'b0;
    repeat (3) tick();
    chk("midrun_state", 64'(state), 64'(M_RUN));
    #2;
    do_reset();

    // Counter: 10 RUN cycles ending with HALT, then held.
    run_cont = 1'b1; tick();
    run_cont = 1'b0;
    repeat (9) tick();
    halt_f = 1'b1; tick();
    halt_f = 1'b0; run_cont = 1'b1;
    repeat (3) tick();
    chk("cnt_after_halt", 64'(cycle_cnt), CntEn ? 64'(10) : 64'(0));
    chk("halt_state", 64'(state), 64'(M_HALT));
    clear_inputs();

    // Randomized traffic with occasional mid-run resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end
      run_cont    = ($urandom_range(7) == 0);
      run_step    = ($urandom_range(7) == 0);
      stall       = ($urandom_range(3) == 0);
      jump        = ($urandom_range(4) == 0);
      branch      = ($urandom_range(5) == 0);
      halt_f      = ($urandom_range(40) == 0);
      pc          = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      jump_addr   = $urandom;
      branch_addr = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
